// File: rtl/reg_file_mp_pkg.sv
// Shared core package for the multi-port register file: default sizing,
// register-address type and the address range check used by the datapath.
package reg_file_mp_pkg;

  localparam int CoreDataWidth = 32;
  localparam int CoreNumRegs   = 32;
  localparam int CoreAddrW     = $clog2(CoreNumRegs);

  typedef logic [CoreAddrW-1:0] reg_addr_t;

  function automatic logic addr_valid(input int unsigned addr, input int unsigned num_regs);
    return addr < num_regs;
  endfunction

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Busy scoreboard: one bit per register, set by allocation, cleared by any
// write port hitting that register; allocation wins over a same-edge clear.
module reg_scoreboard #(
  parameter int NumRegs  = 32,
  parameter int NumWrite = 1,
  parameter bit ZeroReg  = 1'b1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NumRegs-1:0]           i_set_vec,
  input  logic [NumWrite*NumRegs-1:0]  i_wr_dec,
  output logic [NumRegs-1:0]           o_busy_vec
);

  logic [NumRegs-1:0] busy_q;
  logic [NumRegs-1:0] busy_d;
  logic [NumRegs-1:0] clr_s;

  // next busy state: merge per-port clears, then apply sets on top
  always_comb begin
    clr_s = {NumRegs{1'b0}};
    for (int w = 0; w < NumWrite; w++) begin
      clr_s = clr_s | i_wr_dec[w*NumRegs +: NumRegs];
    end
    busy_d    = (busy_q & ~clr_s) | i_set_vec;
    busy_d[0] = ZeroReg ? 1'b0 : busy_d[0];
  end

  // scoreboard flops
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      busy_q <= {NumRegs{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  assign o_busy_vec = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with write-to-read bypass and a producer
// scoreboard that tracks registers awaiting an outstanding write.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int                  DataWidth = CoreDataWidth,
  parameter int                  NumRegs   = CoreNumRegs,
  parameter int                  NumRead   = 2,
  parameter int                  NumWrite  = 1,
  parameter logic [DataWidth-1:0] EmptyReg = '0,
  parameter bit                  ZeroReg   = 1'b1,
  localparam int                 AddrW     = $clog2(NumRegs)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NumRead*AddrW-1:0]      i_rreg,
  output logic [NumRead*DataWidth-1:0]  o_rdata,
  output logic [NumRead-1:0]            o_rbusy,
  input  logic [NumWrite*AddrW-1:0]     i_wreg,
  input  logic [NumWrite*DataWidth-1:0] i_wdata,
  input  logic [NumWrite-1:0]           i_we,
  input  logic [AddrW-1:0]              i_alloc_reg,
  input  logic                          i_alloc_en,
  output logic [NumRegs-1:0]            o_busy_vec
);

  localparam logic [NumRegs-1:0] OneHot0 = {{(NumRegs-1){1'b0}}, 1'b1};
  // register 0 is masked out of every decode when it is hardwired
  localparam logic [NumRegs-1:0] WrMask  = ZeroReg ? ~OneHot0 : {NumRegs{1'b1}};

  logic [DataWidth-1:0]        regs_q [NumRegs];
  logic [DataWidth-1:0]        regs_d [NumRegs];
  logic [NumWrite*NumRegs-1:0] wdec_s;
  logic [NumRegs-1:0]          set_s;
  logic [NumRegs-1:0]          busy_s;

  // shifting past NumRegs yields zero, so out-of-range addresses decode to nothing
  for (genvar w = 0; w < NumWrite; w++) begin : g_wdec
    assign wdec_s[w*NumRegs +: NumRegs] =
      i_we[w] ? ((OneHot0 << i_wreg[w*AddrW +: AddrW]) & WrMask) : {NumRegs{1'b0}};
  end

  assign set_s = i_alloc_en ? ((OneHot0 << i_alloc_reg) & WrMask) : {NumRegs{1'b0}};

  // next register contents: later write ports override earlier ones
  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      regs_d[i] = regs_q[i];
      for (int w = 0; w < NumWrite; w++) begin
        regs_d[i] = wdec_s[w*NumRegs + i] ? i_wdata[w*DataWidth +: DataWidth] : regs_d[i];
      end
    end
  end

  // register storage
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= (ZeroReg && i == 0) ? {DataWidth{1'b0}} : EmptyReg;
      end
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  for (genvar r = 0; r < NumRead; r++) begin : g_rd
    logic [AddrW-1:0]     addr_s;
    logic [NumRegs-1:0]   dec_s;
    logic [DataWidth-1:0] rdata_s;
    logic                 hit_s;
    logic                 valid_s;

    assign addr_s  = i_rreg[r*AddrW +: AddrW];
    assign valid_s = addr_valid(32'(addr_s), NumRegs);

    // bypass mux: highest-index matching write port supplies the data
    always_comb begin
      rdata_s = EmptyReg;
      hit_s   = 1'b0;
      dec_s   = {NumRegs{1'b0}};
      if (valid_s) begin
        rdata_s = regs_q[addr_s];
        for (int w = 0; w < NumWrite; w++) begin
          dec_s   = wdec_s[w*NumRegs +: NumRegs];
          rdata_s = dec_s[addr_s] ? i_wdata[w*DataWidth +: DataWidth] : rdata_s;
          hit_s   = hit_s | dec_s[addr_s];
        end
      end else begin
        rdata_s = EmptyReg;
      end
    end

    assign o_rdata[r*DataWidth +: DataWidth] = rdata_s;
    assign o_rbusy[r] = valid_s & busy_s[addr_s] & ~hit_s;
  end

  reg_scoreboard #(
    .NumRegs  (NumRegs),
    .NumWrite (NumWrite),
    .ZeroReg  (ZeroReg)
  ) u_scoreboard (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_set_vec  (set_s),
    .i_wr_dec   (wdec_s),
    .o_busy_vec (busy_s)
  );

  assign o_busy_vec = busy_s;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp with two read and two write ports.
module tb_reg_file_mp;
  import reg_file_mp_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rreg;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic [9:0]  wreg;
  logic [63:0] wdata;
  logic [1:0]  we;
  reg_addr_t   alloc_reg;
  logic        alloc_en;
  logic [31:0] busy_vec;

  int n_vec = 0;
  int n_err = 0;

  reg_file_mp #(
    .DataWidth (32),
    .NumRegs   (32),
    .NumRead   (2),
    .NumWrite  (2),
    .EmptyReg  (32'h0),
    .ZeroReg   (1'b1)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_rreg      (rreg),
    .o_rdata     (rdata),
    .o_rbusy     (rbusy),
    .i_wreg      (wreg),
    .i_wdata     (wdata),
    .i_we        (we),
    .i_alloc_reg (alloc_reg),
    .i_alloc_en  (alloc_en),
    .o_busy_vec  (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one edge; inputs change and checks happen 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we       = 2'b00;
    alloc_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rreg = '0; wreg = '0; wdata = '0; we = 2'b00;
    alloc_reg = '0; alloc_en = 1'b0;
    #2;
    rreg = {5'd5, 5'd5};
    #1;
    chk("rst_rdata", rdata[31:0], 32'h0);
    chk("rst_busy_vec", busy_vec, 32'h0);
    chk("rst_rbusy", {30'd0, rbusy}, 32'h0);
    // bypass stays live in reset, but the edge itself must be discarded
    wreg = {5'd0, 5'd5}; wdata = {32'h0, 32'h000000AA}; we = 2'b01;
    alloc_reg = 5'd6; alloc_en = 1'b1;
    #1;
    chk("rst_bypass", rdata[31:0], 32'h000000AA);
    tick();
    idle();
    #1;
    chk("rst_edge_wr_dropped", rdata[31:0], 32'h0);
    chk("rst_edge_alloc_dropped", busy_vec, 32'h0);
    rst_n = 1'b1;

    // write x5 port 0 with same-cycle read on both ports
    wreg = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF}; we = 2'b01;
    rreg = {5'd5, 5'd5};
    #1;
    chk("byp_rd0", rdata[31:0], 32'hDEADBEEF);
    chk("byp_rd1", rdata[63:32], 32'hDEADBEEF);
    tick();
    idle();
    #1;
    chk("stored_x5", rdata[31:0], 32'hDEADBEEF);

    // both ports hit x7: port 1 wins
    wreg = {5'd7, 5'd7}; wdata = {32'h00000022, 32'h00000011}; we = 2'b11;
    rreg = {5'd5, 5'd7};
    #1;
    chk("conf_byp", rdata[31:0], 32'h00000022);
    chk("other_port_x5", rdata[63:32], 32'hDEADBEEF);
    tick();
    idle();
    #1;
    chk("conf_stored", rdata[31:0], 32'h00000022);

    // x0 hardwired: no write, no bypass, never busy
    wreg = {5'd0, 5'd0}; wdata = {32'h0, 32'hFFFFFFFF}; we = 2'b01;
    alloc_reg = 5'd0; alloc_en = 1'b1;
    rreg = {5'd0, 5'd0};
    #1;
    chk("x0_no_byp", rdata[31:0], 32'h0);
    tick();
    idle();
    #1;
    chk("x0_read", rdata[31:0], 32'h0);
    chk("x0_busy", {31'd0, busy_vec[0]}, 32'h0);

    // alloc x3, stays busy, write clears next edge
    alloc_reg = 5'd3; alloc_en = 1'b1;
    tick();
    idle();
    rreg = {5'd0, 5'd3};
    #1;
    chk("alloc3_busy", busy_vec, 32'h00000008);
    chk("alloc3_rbusy", {31'd0, rbusy[0]}, 32'h1);
    tick();
    wreg = {5'd0, 5'd3}; wdata = {32'h0, 32'h00003333}; we = 2'b01;
    #1;
    chk("wr3_rbusy_masked", {31'd0, rbusy[0]}, 32'h0);
    chk("wr3_busy_still", busy_vec, 32'h00000008);
    tick();
    idle();
    #1;
    chk("wr3_busy_clear", busy_vec, 32'h0);
    chk("wr3_data", rdata[31:0], 32'h00003333);

    // alloc and write x4 on same edge: producer stays pending
    alloc_reg = 5'd4; alloc_en = 1'b1;
    wreg = {5'd0, 5'd4}; wdata = {32'h0, 32'h00004444}; we = 2'b01;
    tick();
    idle();
    rreg = {5'd4, 5'd4};
    #1;
    chk("alloc_wr4_busy", busy_vec, 32'h00000010);
    chk("alloc_wr4_rbusy", {30'd0, rbusy}, 32'h3);
    chk("alloc_wr4_data", rdata[63:32], 32'h00004444);
    // write port 1 also clears busy
    wreg = {5'd4, 5'd0}; wdata = {32'h00005555, 32'h0}; we = 2'b10;
    tick();
    idle();
    #1;
    chk("p1_clear4", busy_vec, 32'h0);
    chk("p1_data4", rdata[31:0], 32'h00005555);

    // fill x1..x31, allocate two, then reset asynchronously mid-cycle
    for (int i = 1; i < 32; i++) begin
      wreg = {5'd0, 5'(i)}; wdata = {32'h0, 32'h00000100 + 32'(i)}; we = 2'b01;
      tick();
    end
    idle();
    alloc_reg = 5'd9; alloc_en = 1'b1;
    tick();
    alloc_reg = 5'd10;
    tick();
    idle();
    rreg = {5'd31, 5'd9};
    #1;
    chk("fill_x9", rdata[31:0], 32'h00000109);
    chk("fill_x31", rdata[63:32], 32'h0000011F);
    chk("fill_busy", busy_vec, 32'h00000600);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_vec, 32'h0);
    for (int i = 1; i < 32; i += 2) begin
      rreg = {5'(i + 1), 5'(i)};
      #1;
      chk("mid_rst_rd0", rdata[31:0], 32'h0);
      if (i < 31) chk("mid_rst_rd1", rdata[63:32], 32'h0);
      chk("mid_rst_rbusy", {30'd0, rbusy}, 32'h0);
    end
    tick();
    rst_n = 1'b1;
    rreg = {5'd10, 5'd9};
    #1;
    chk("post_rst_x9", rdata[31:0], 32'h0);
    chk("post_rst_busy", busy_vec, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter DataWidth, default 32, register width in bits.
REQ-002 SHALL have parameter NumRegs, default 32, register count (2..64); AddrW = $clog2(NumRegs).
REQ-003 SHALL have parameter NumRead, default 2, read port count (1..4).
REQ-004 SHALL have parameter NumWrite, default 1, write port count (1..2).
REQ-005 SHALL have parameter EmptyReg, default 0, reset value of every register.
REQ-006 SHALL have parameter ZeroReg, default 1, register 0 hardwired to 0, never written and never busy.
REQ-007 SHALL use one clock and an asynchronous active-low reset, ports i_clk and i_rst.
REQ-008 SHALL have the following ports, one per line (name  direction  width  meaning):
- i_clk  in  1  clock
- i_rst  in  1  async reset, active low
- i_rreg  in  NumRead x AddrW  read addresses
- o_rdata  out  NumRead x DataWidth  read data
- o_rbusy  out  NumRead  addressed register has a pending producer
- i_wreg  in  NumWrite x AddrW  write addresses
- i_wdata  in  NumWrite x DataWidth  write data
- i_we  in  NumWrite  write enables
- i_alloc_reg  in  AddrW  register being allocated to a new producer
- i_alloc_en  in  1  allocate strobe
- o_busy_vec  out  NumRegs  scoreboard state, bit per register

Function
REQ-009 SHALL update registers on posedge i_clk; read paths combinational, zero-cycle latency.
REQ-010 SHALL bypass: o_rdata[r] = i_wdata[w] of the highest-index w with i_we[w], i_wreg[w]==i_rreg[r], else stored value.
REQ-011 SHALL, on a same-cycle write conflict to one register, store data from the highest-index write port.
REQ-012 SHALL, with ZeroReg=1, ignore writes to register 0 and return 0 on reads of it (no bypass).
REQ-013 SHALL ignore writes, allocations and bypass for addresses >= NumRegs; reads of them return EmptyReg, o_rbusy 0.
REQ-014 SHALL set busy[i_alloc_reg] on a clock edge with i_alloc_en=1.
REQ-015 SHALL clear busy[a] on a clock edge with a write to a and no same-cycle allocation of a.
REQ-016 SHALL keep busy[a] set when allocation and write of a coincide (new producer wins).
REQ-017 SHALL drive o_rbusy[r] = busy[i_rreg[r]] AND NOT (any enabled write to i_rreg[r] this cycle).
REQ-018 SHALL drive o_busy_vec directly from scoreboard flops, bit 0 constant 0 when ZeroReg=1.

Reset
REQ-019 SHALL, while i_rst=0, force all registers to EmptyReg (register 0 to 0 when ZeroReg=1) and all busy bits to 0, asynchronously.
REQ-020 SHALL, during reset, drive o_rdata with reset contents, o_rbusy=0, o_busy_vec=0; bypass stays active.
REQ-021 SHALL discard any write or allocation presented on the first edge after reset release if i_rst was low at that edge.

Structure
REQ-022 SHALL take DataWidth, NumRegs defaults and the reg-address typedef from the shared core package.
REQ-023 SHALL implement the scoreboard as sub-module reg_scoreboard (set/clear vector, NumRegs, NumWrite).
REQ-024 SHALL build write decode and bypass muxes via generate loops over ports; no vendor memory primitives.

Verification
REQ-025 Write x5=0xDEADBEEF port 0, read x5 same cycle on both ports -> o_rdata=0xDEADBEEF (bypass), next cycle stored.
REQ-026 NumWrite=2: both ports write x7 (0x11, 0x22) -> x7 reads 0x22.
REQ-027 Write x0=0xFFFFFFFF with ZeroReg=1 -> x0 reads 0, o_busy_vec[0]=0.
REQ-028 Alloc x3 cycle 0 -> o_busy_vec[3]=1 cycle 1; write x3 cycle 2 -> o_rbusy=0 in cycle 2, busy clears cycle 3.
REQ-029 Alloc x4 and write x4 same edge -> busy[4] remains 1.
REQ-030 Assert i_rst mid-run after writes to x1..x31 and allocs -> all reads EmptyReg, o_busy_vec=0 immediately.
